tcdm_req_initiator: RTL and testbench

TCDM_REQ_INITIATOR -- requirements
Module: tcdm_req_initiator

---
 rtl/tcdm_initiator_pkg.sv | 17 +
 rtl/xbar_tcdm_bus.sv | 23 ++
 rtl/tcdm_rsp_watchdog.sv | 30 +++
 rtl/tcdm_req_initiator.sv | 135 +++++++++++++
 tb/tb_tcdm_req_initiator.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcdm_initiator_pkg.sv
// Shared types for the TCDM request initiator.
// FSM encoding and outstanding-counter sizing helper.
package tcdm_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(
    input int unsigned max_out
  );
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/xbar_tcdm_bus.sv
// TCDM crossbar port bundle.
// Master drives the request, slave answers with grant/response.
interface XBAR_TCDM_BUS;
  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        r_valid;
  logic [31:0] r_rdata;
  logic        r_opc;

  modport Master (
    output req, add, wen, wdata, be,
    input  gnt, r_valid, r_rdata, r_opc
  );

  modport Slave (
    input  req, add, wen, wdata, be,
    output gnt, r_valid, r_rdata, r_opc
  );
endinterface

// File: rtl/tcdm_rsp_watchdog.sv
// Response watchdog: counts enabled cycles without a kick and
// emits a one-cycle expire pulse on the TIMEOUT_CYCLES-th one.
module tcdm_rsp_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic enable,
  input  logic kick,
  output logic expire
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;

  assign expire = enable & ~kick & (cnt_q == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (!enable || kick || expire) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/tcdm_req_initiator.sv
// Single-slot TCDM request initiator with outstanding-limit,
// registered responses, sticky error/timeout status.
module tcdm_req_initiator
  import tcdm_initiator_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [31:0]   cmd_addr,
  input  logic          cmd_wen,
  input  logic [31:0]   cmd_wdata,
  input  logic [3:0]    cmd_be,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          err_sticky,
  output logic          timeout_sticky,
  input  logic          clr_status,
  XBAR_TCDM_BUS.Master  tcdm_master
);

  localparam int unsigned CW = cnt_width(MAX_OUTSTANDING);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  state_e        state_q, state_d;
  logic [31:0]   add_q, wdata_q;
  logic          wen_q;
  logic [3:0]    be_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept, issue, retire, expire;

  assign cmd_ready = i_rst_n & (state_q == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;

  assign tcdm_master.req   = (state_q == ST_REQ);
  assign tcdm_master.add   = add_q;
  assign tcdm_master.wen   = wen_q;
  assign tcdm_master.wdata = wdata_q;
  assign tcdm_master.be    = be_q;

  assign issue  = tcdm_master.req & tcdm_master.gnt;
  // Stray responses with nothing outstanding are dropped.
  assign retire = tcdm_master.r_valid & (cnt_q != '0);

  tcdm_rsp_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .enable (cnt_q != '0),
    .kick   (tcdm_master.r_valid),
    .expire (expire)
  );

  always_comb begin
    cnt_d = cnt_q + CW'(issue) - CW'(retire);
    if (expire) begin
      cnt_d = issue ? CW'(1) : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (tcdm_master.gnt) begin
          state_d = (cnt_d == MAX_C) ? ST_FULL : ST_IDLE;
        end
      end
      ST_FULL: begin
        if (cnt_d < MAX_C) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      add_q   <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      add_q   <= cmd_addr;
      wen_q   <= cmd_wen;
      wdata_q <= cmd_wdata;
      be_q    <= cmd_be;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= retire;
      if (retire) begin
        rsp_rdata <= tcdm_master.r_rdata;
        rsp_err   <= tcdm_master.r_opc;
      end
    end
  end

  // A new event in the clear cycle keeps the flag set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_sticky     <= 1'b0;
      timeout_sticky <= 1'b0;
    end else begin
      err_sticky <= (retire & tcdm_master.r_opc)
                  | (err_sticky & ~clr_status);
      timeout_sticky <= expire
                      | (timeout_sticky & ~clr_status);
    end
  end

endmodule

// File: tb/tb_tcdm_req_initiator.sv
// Directed bench for tcdm_req_initiator: vector table for single
// transactions plus hand-timed multi-cycle sequences.
module tb_tcdm_req_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        cmd_wen;
  logic [3:0]  cmd_be;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        err_sticky, timeout_sticky;
  logic        clr_status;
  logic        gnt_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  XBAR_TCDM_BUS bus ();
  assign bus.gnt = gnt_en & bus.req;

  tcdm_req_initiator #(
    .MAX_OUTSTANDING(2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_wen       (cmd_wen),
    .cmd_wdata     (cmd_wdata),
    .cmd_be        (cmd_be),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .err_sticky    (err_sticky),
    .timeout_sticky(timeout_sticky),
    .clr_status    (clr_status),
    .tcdm_master   (bus.Master)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        opc;
    logic        exp_err;
  } vec_t;

  vec_t vecs [4];

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cmd_valid   = 1'b0;
    cmd_addr    = '0;
    cmd_wen     = 1'b0;
    cmd_wdata   = '0;
    cmd_be      = '0;
    clr_status  = 1'b0;
    gnt_en      = 1'b1;
    bus.r_valid = 1'b0;
    bus.r_rdata = '0;
    bus.r_opc   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] w_addr [3];
    logic [31:0] r_dat [3];
    int idx;
    logic exp_r;

    vecs[0] = '{1'b0, 32'h0000_0040, 32'hA5A5_0001, 4'hF,
                32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_1000, 32'h0000_0000, 4'hF,
                32'hDEAD_BEEF, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 32'h0000_2004, 32'h1234_5678, 4'h3,
                32'hCAFE_0002, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 4'hC,
                32'hFFFF_FFFF, 1'b0, 1'b1};

    idle_in();
    #2;
    chk1("rst_ready", cmd_ready, 1'b0);
    chk1("rst_req", bus.req, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_rdata", rsp_rdata, 32'h0);
    chk1("rst_err_sticky", err_sticky, 1'b0);
    chk1("rst_to_sticky", timeout_sticky, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      cyc();
      cmd_valid = 1'b1;
      cmd_wen   = vecs[i].wen;
      cmd_addr  = vecs[i].addr;
      cmd_wdata = vecs[i].wdata;
      cmd_be    = vecs[i].be;
      #1;
      chk1($sformatf("v%0d_ready", i), cmd_ready, 1'b1);
      cyc();
      cmd_valid = 1'b0;
      #1;
      chk1($sformatf("v%0d_req", i), bus.req, 1'b1);
      chk1($sformatf("v%0d_ready_req", i), cmd_ready, 1'b0);
      chk32($sformatf("v%0d_add", i), bus.add, vecs[i].addr);
      chk1($sformatf("v%0d_wen", i), bus.wen, vecs[i].wen);
      chk32($sformatf("v%0d_wdata", i), bus.wdata,
            vecs[i].wdata);
      chk32($sformatf("v%0d_be", i), {28'h0, bus.be},
            {28'h0, vecs[i].be});
      cyc();
      bus.r_valid = 1'b1;
      bus.r_rdata = vecs[i].rdata;
      bus.r_opc   = vecs[i].opc;
      #1;
      chk1($sformatf("v%0d_req_drop", i), bus.req, 1'b0);
      chk1($sformatf("v%0d_rsp_early", i), rsp_valid, 1'b0);
      cyc();
      bus.r_valid = 1'b0;
      bus.r_opc   = 1'b0;
      #1;
      chk1($sformatf("v%0d_rsp_valid", i), rsp_valid, 1'b1);
      chk32($sformatf("v%0d_rsp_rdata", i), rsp_rdata,
            vecs[i].rdata);
      chk1($sformatf("v%0d_rsp_err", i), rsp_err, vecs[i].opc);
      chk1($sformatf("v%0d_err_sticky", i), err_sticky,
           vecs[i].exp_err);
      cyc();
      #1;
      chk1($sformatf("v%0d_rsp_pulse", i), rsp_valid, 1'b0);
    end

    // Three writes, responses 5 cycles after each grant.
    w_addr = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
    r_dat  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      cyc();
      cmd_valid = (idx < 3);
      cmd_wen   = 1'b0;
      cmd_be    = 4'hF;
      cmd_addr  = (idx < 3) ? w_addr[idx] : 32'h0;
      cmd_wdata = 32'h0000_0F00 + 32'(idx);
      bus.r_valid = (c == 6) || (c == 8) || (c == 13);
      bus.r_rdata = (c == 6) ? r_dat[0] :
                    (c == 8) ? r_dat[1] : r_dat[2];
      bus.r_opc = 1'b0;
      #1;
      if (c <= 8) begin
        exp_r = (c == 0) || (c == 2) || (c == 7);
        chk1($sformatf("bb_ready_c%0d", c), cmd_ready, exp_r);
      end
      if (c >= 4 && c <= 6) begin
        chk1($sformatf("bb_full_req_c%0d", c), bus.req, 1'b0);
      end
      if (c == 1) chk32("bb_add0", bus.add, w_addr[0]);
      if (c == 3) chk32("bb_add1", bus.add, w_addr[1]);
      if (c == 8) chk32("bb_add2", bus.add, w_addr[2]);
      exp_r = (c == 7) || (c == 9) || (c == 14);
      chk1($sformatf("bb_rsp_c%0d", c), rsp_valid, exp_r);
      if (c == 7) chk32("bb_rdata0", rsp_rdata, r_dat[0]);
      if (c == 9) chk32("bb_rdata1", rsp_rdata, r_dat[1]);
      if (c == 14) chk32("bb_rdata2", rsp_rdata, r_dat[2]);
      if (cmd_valid && cmd_ready) idx++;
    end
    idle_in();

    // Grant withheld for 4 req cycles.
    cyc();
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_3000;
    cmd_wen   = 1'b0;
    cmd_wdata = 32'h5555_AAAA;
    cmd_be    = 4'h5;
    gnt_en    = 1'b0;
    #1;
    chk1("st_ready", cmd_ready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      cmd_valid = 1'b0;
      cmd_addr  = 32'hBAD0_0000 + 32'(k);
      cmd_wdata = 32'h0;
      cmd_wen   = 1'b1;
      cmd_be    = 4'hA;
      gnt_en    = (k == 4);
      #1;
      chk1($sformatf("st_req_%0d", k), bus.req, 1'b1);
      chk32($sformatf("st_add_%0d", k), bus.add, 32'h0000_3000);
      chk32($sformatf("st_wdata_%0d", k), bus.wdata,
            32'h5555_AAAA);
      chk1($sformatf("st_wen_%0d", k), bus.wen, 1'b0);
      chk32($sformatf("st_be_%0d", k), {28'h0, bus.be}, 32'h5);
    end
    cyc();
    gnt_en      = 1'b1;
    bus.r_valid = 1'b1;
    bus.r_rdata = 32'h0BAD_F00D;
    #1;
    chk1("st_req_drop", bus.req, 1'b0);
    cyc();
    bus.r_valid = 1'b0;
    #1;
    chk1("st_rsp_valid", rsp_valid, 1'b1);
    chk32("st_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
    idle_in();

    // Two reads never answered: FULL, then watchdog expiry.
    for (int c = 0; c < 20; c++) begin
      cyc();
      cmd_valid = (c == 0) || (c == 2) || (c == 18);
      cmd_wen   = 1'b1;
      cmd_be    = 4'hF;
      cmd_addr  = 32'h0000_4000 + 32'(c);
      #1;
      if (c == 4) chk1("to_full_ready", cmd_ready, 1'b0);
      if (c == 17) begin
        chk1("to_sticky_pre", timeout_sticky, 1'b0);
        chk1("to_ready_pre", cmd_ready, 1'b0);
      end
      if (c == 18) begin
        chk1("to_sticky_set", timeout_sticky, 1'b1);
        chk1("to_ready_idle", cmd_ready, 1'b1);
      end
      if (c == 19) begin
        chk1("to_next_req", bus.req, 1'b1);
        chk32("to_next_add", bus.add, 32'h0000_4012);
      end
    end
    cyc();
    cmd_valid   = 1'b0;
    bus.r_valid = 1'b1;
    bus.r_rdata = 32'h0000_0077;
    #1;
    cyc();
    bus.r_valid = 1'b0;
    #1;
    chk1("to_next_rsp", rsp_valid, 1'b1);
    chk32("to_next_rdata", rsp_rdata, 32'h0000_0077);

    cyc();
    clr_status = 1'b1;
    #1;
    cyc();
    clr_status = 1'b0;
    #1;
    chk1("clr_to_sticky", timeout_sticky, 1'b0);
    chk1("clr_err_sticky", err_sticky, 1'b0);

    // Clear in the same cycle as an error response.
    cyc();
    cmd_valid = 1'b1;
    cmd_wen   = 1'b1;
    cmd_addr  = 32'h0000_5000;
    #1;
    cyc();
    cmd_valid = 1'b0;
    #1;
    cyc();
    bus.r_valid = 1'b1;
    bus.r_rdata = 32'h0000_0001;
    bus.r_opc   = 1'b1;
    clr_status  = 1'b1;
    #1;
    cyc();
    bus.r_valid = 1'b0;
    bus.r_opc   = 1'b0;
    clr_status  = 1'b0;
    #1;
    chk1("setwin_err_sticky", err_sticky, 1'b1);
    chk1("setwin_rsp_err", rsp_err, 1'b1);

    // Reset with two outstanding writes.
    for (int c = 0; c < 4; c++) begin
      cyc();
      cmd_valid = (c == 0) || (c == 2);
      cmd_wen   = 1'b0;
      cmd_addr  = 32'h0000_6000 + 32'(c);
      #1;
    end
    cyc();
    cmd_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk1("mr_ready", cmd_ready, 1'b0);
    chk1("mr_req", bus.req, 1'b0);
    chk1("mr_err_sticky", err_sticky, 1'b0);
    chk32("mr_rdata", rsp_rdata, 32'h0);
    cyc();
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      bus.r_valid = (c < 2);
      bus.r_rdata = 32'hEEEE_0000 + 32'(c);
      #1;
      chk1($sformatf("mr_no_rsp_%0d", c), rsp_valid, 1'b0);
    end
    bus.r_valid = 1'b0;
    repeat (20) cyc();
    chk1("mr_no_timeout", timeout_sticky, 1'b0);
    chk1("mr_ready_after", cmd_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
